instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have these ports (name, direction, width, meaning), clock and reset first:
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high reset
  in_valid  in  1  request offered
  in_ready  out  1  request accepted when in_valid && in_ready
  in_fmt  in  3  0=R, 1=I, 2=I-shift, 3=S, 4=B, 5=U, 6=J, 7=reserved
  in_opcode  in  7  opcode; bits [1:0] forced to 2'b11 in the output
  in_rd, in_rs1, in_rs2  in  5 each  register fields
  in_funct3  in  3  funct3
  in_funct7  in  7  funct7 (R and I-shift formats only)
  in_imm  in  32  signed byte offset / immediate value
  out_valid  out  1  encoded word available
  out_ready  in  1  consumer takes the word when out_valid && out_ready
  out_instr  out  32  encoded RV32I instruction word
  out_err  out  1  immediate out of range or reserved format
  err_count  out  16  saturating count of words delivered with out_err=1
REQ-002 Clock and reset SHALL be a single clock clk and an asynchronous, active-high reset named reset.

Function
REQ-003 Field placement SHALL be the exact inverse of RV32I immediate decoding: I imm[11:0]->[31:20]; I-shift imm[4:0]->[24:20], funct7->[31:25]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; B imm[12|10:5]->[31|30:25], imm[4:1|11]->[11:8|7]; U imm[31:12]->[31:12]; J imm[20|10:1|11|19:12]->[31|30:21|20|19:12].
REQ-004 Fields not present in a format (e.g. rd in S/B, rs1/rs2 in U/J) SHALL be encoded as zero.
REQ-005 Reserved format (7) SHALL produce out_instr=0 and out_err=1.
REQ-006 Latency SHALL be one cycle: a request accepted at edge N is presented with out_valid=1 after edge N.
REQ-007 Output buffering SHALL be a 2-entry skid buffer; in_ready = (fewer than 2 entries held); full throughput (one word per cycle) while out_ready=1.
REQ-008 out_valid, out_instr and out_err SHALL remain stable while out_valid && !out_ready.
REQ-009 Words SHALL leave in acceptance order; no word dropped or duplicated.
REQ-010 Simultaneous accept and deliver when 2 entries are held SHALL be impossible (in_ready=0); with 1 entry held, both SHALL occur in the same cycle and occupancy stays 1.
REQ-011 err_count SHALL increment on each delivery handshake with out_err=1, saturating at 16'hFFFF.

Reset
REQ-012 reset SHALL asynchronously empty the buffer: out_valid=0, out_instr=0, out_err=0, err_count=0; in_ready=1 on the first edge after release.
REQ-013 Reset asserted mid-transfer SHALL discard all held words; none reappear after release.

Configuration
REQ-014 With RANGE_CHECK_EN defined, out_err SHALL also be set for: I/S imm outside -2048..2047; I-shift imm outside 0..31; B imm outside -4096..4094 or odd; U imm[11:0]!=0; J imm outside -1048576..1048574 or odd; the word is still encoded from the truncated fields.
REQ-015 Without RANGE_CHECK_EN, out_err SHALL be set only for reserved format and the range logic SHALL be absent.

Structure
REQ-016 Format codes (fmt_t enum) and opcode constants SHALL live in the shared package, alongside the decoder's format definitions.
REQ-017 Combinational field packing and range checking SHALL be a sub-module instr_pack; instr_encoder holds the skid buffer and error counter.

Verification
REQ-018 I, ADDI rd=1 rs1=0 f3=0 imm=-1, opcode 7'h13 -> out_instr=32'hFFF00093, out_err=0, one cycle later.
REQ-019 S, SW rs2=2 rs1=3 f3=2 imm=8, opcode 7'h23 -> 32'h0021A423.
REQ-020 J, JAL rd=1 imm=2048, opcode 7'h6F -> 32'h001000EF; round-trip through the decoder returns imm=2048.
REQ-021 B, imm=3 with RANGE_CHECK_EN -> out_err=1, err_count increments to 1 on delivery; without the macro out_err=0.
REQ-022 out_ready=0 while 3 requests are offered back to back -> in_ready drops after 2 accepts; on release, 3 words appear in order with no loss.
REQ-023 reset pulse while 2 words are held -> out_valid=0 immediately, err_count=0, no stale word after release.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: RV32I format codes, opcode constants, buffer entry type and immediate decoder.
package instr_encoder_pkg;
  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_ISH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_RSV
  } fmt_t;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } word_t;
  function automatic logic [31:0] decode_imm(fmt_t f, logic [31:0] w);
    case (f)
      FMT_I:   return {{20{w[31]}}, w[31:20]};
      FMT_ISH: return {27'd0, w[24:20]};
      FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   return {w[31:12], 12'd0};
      FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction
endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational RV32I field packing; optional immediate range check under RANGE_CHECK_EN.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);
  fmt_t f;
  logic [6:0] op;
  logic rng;
  assign f  = fmt_t'(fmt_i);
  assign op = opcode_i | 7'b0000011;
  always_comb begin
    instr_o = 32'd0;
    case (f)
      FMT_R:   instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op};
      FMT_I:   instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, op};
      FMT_ISH: instr_o = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, op};
      FMT_S:   instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op};
      FMT_B:   instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], op};
      FMT_U:   instr_o = {imm_i[31:12], rd_i, op};
      FMT_J:   instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op};
      default: instr_o = 32'd0;
    endcase
  end
`ifdef RANGE_CHECK_EN
  logic signed [31:0] s;
  assign s = imm_i;
  always_comb begin
    rng = 1'b0;
    case (f)
      FMT_I, FMT_S: rng = s < -32'sd2048 || s > 32'sd2047;
      FMT_ISH:      rng = imm_i > 32'd31;
      FMT_B:        rng = s < -32'sd4096 || s > 32'sd4094 || imm_i[0];
      FMT_U:        rng = imm_i[11:0] != 12'd0;
      FMT_J:        rng = s < -32'sd1048576 || s > 32'sd1048574 || imm_i[0];
      default:      rng = 1'b0;
    endcase
  end
`else
  assign rng = 1'b0;
`endif
  assign err_o = (f == FMT_RSV) | rng;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I encoder with 2-entry skid buffer and saturating error counter.
// Define RANGE_CHECK_EN to flag out-of-range immediates in out_err.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_count
);
  word_t nw, e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic push, pop;
  instr_pack u_pack (
    .fmt_i(in_fmt), .opcode_i(in_opcode), .rd_i(in_rd), .rs1_i(in_rs1), .rs2_i(in_rs2),
    .funct3_i(in_funct3), .funct7_i(in_funct7), .imm_i(in_imm),
    .instr_o(nw.instr), .err_o(nw.err)
  );
  assign in_ready  = cnt_q != 2'd2;
  assign out_valid = cnt_q != 2'd0;
  assign out_instr = out_valid ? e0_q.instr : 32'd0;
  assign out_err   = out_valid & e0_q.err;
  assign err_count = err_cnt_q;
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  // head entry takes the new word when it would otherwise be empty, else shifts from e1 on pop
  always_comb begin
    e0_d = (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) ? nw : pop ? e1_q : e0_q;
    e1_d = (push && cnt_q == 2'd1 && !pop) ? nw : e1_q;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    err_cnt_d = (pop && e0_q.err && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= 2'd0;
      err_cnt_q <= 16'd0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule
